// File: rtl/burst_mem_ctrl.sv
// burst_mem_ctrl: moves bursts of 1..MAX_LINES cache lines between the CPU
// word bus and the DMA cache-line FIFOs. It unpacks lines into words on reads
// and packs words into lines on writes.
module burst_mem_ctrl #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned LINE_W    = 512,
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned SIZE_W    = 33,
  parameter int unsigned MAX_LINES = 16,
  parameter int unsigned CNT_W     = $clog2(MAX_LINES) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] io_address,
  input  logic [CNT_W-1:0]  num_lines,
  input  logic [WORD_W-1:0] cpu_wdata,
  input  logic              cpu_wvalid,
  output logic              cpu_wready,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              cpu_rready,
  output logic              ready,
  output logic              tx_done,
  output logic              err,
  input  logic [LINE_W-1:0] host_rd_data,
  input  logic              host_empty,
  input  logic              host_full,
  input  logic              host_wr_done,
  output logic              host_rd_en,
  output logic              host_wr_en,
  output logic              host_rd_go,
  output logic              host_wr_go,
  output logic [ADDR_W-1:0] host_rd_addr,
  output logic [ADDR_W-1:0] host_wr_addr,
  output logic [SIZE_W-1:0] host_rd_size,
  output logic [SIZE_W-1:0] host_wr_size,
  output logic [LINE_W-1:0] host_wr_data
);

  localparam int unsigned WPL    = LINE_W / WORD_W;
  localparam int unsigned WCNT_W = (WPL > 1) ? $clog2(WPL) : 1;

  localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(WPL - 1);
  localparam logic [CNT_W-1:0]  LINES_MAX = CNT_W'(MAX_LINES);

  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_RD_GO    = 4'd1;
  localparam logic [3:0] S_RD_WAIT  = 4'd2;
  localparam logic [3:0] S_RD_DRAIN = 4'd3;
  localparam logic [3:0] S_WR_GO    = 4'd4;
  localparam logic [3:0] S_WR_FILL  = 4'd5;
  localparam logic [3:0] S_WR_PUSH  = 4'd6;
  localparam logic [3:0] S_WR_WAIT  = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;

  logic [3:0]        state_q,     state_d;
  logic [LINE_W-1:0] buf_q,       buf_d;
  logic [WCNT_W-1:0] wcnt_q,      wcnt_d;
  logic [CNT_W-1:0]  lcnt_q,      lcnt_d;
  logic [CNT_W-1:0]  size_q,      size_d;
  logic [ADDR_W-1:0] rd_addr_q,   rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
  logic [SIZE_W-1:0] rd_size_q,   rd_size_d;
  logic [SIZE_W-1:0] wr_size_q,   wr_size_d;
  logic              err_d;

  logic              ready_q;
  logic              rd_go_q;
  logic              wr_go_q;
  logic              rvalid_q;
  logic              wready_q;
  logic              tx_done_q;
  logic              err_q;

  logic              rd_en_c;
  logic              wr_en_c;
  logic              last_line_c;
  logic              op_valid_c;
  logic              size_bad_c;

  // The line now completing is the final one of the burst.
  assign last_line_c = (lcnt_q + CNT_W'(1)) == size_q;
  assign op_valid_c  = (op == OP_READ) || (op == OP_WRITE);
  assign size_bad_c  = (num_lines == '0) || (num_lines > LINES_MAX);

  // Next-state, datapath and FIFO strobe decode.
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    wcnt_d    = wcnt_q;
    lcnt_d    = lcnt_q;
    size_d    = size_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    rd_size_d = rd_size_q;
    wr_size_d = wr_size_q;
    err_d     = 1'b0;
    rd_en_c   = 1'b0;
    wr_en_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (op_valid_c) begin
          if (size_bad_c) begin
            err_d = 1'b1;
          end else begin
            size_d = num_lines;
            lcnt_d = '0;
            wcnt_d = '0;
            if (op == OP_READ) begin
              rd_addr_d = io_address;
              rd_size_d = SIZE_W'(num_lines);
              state_d   = S_RD_GO;
            end else begin
              wr_addr_d = io_address;
              wr_size_d = SIZE_W'(num_lines);
              state_d   = S_WR_GO;
            end
          end
        end
      end

      S_RD_GO: begin
        state_d = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        // Show-ahead FIFO: the head line is valid while not empty.
        if (!host_empty) begin
          rd_en_c = 1'b1;
          buf_d   = host_rd_data;
          wcnt_d  = '0;
          state_d = S_RD_DRAIN;
        end
      end

      S_RD_DRAIN: begin
        if (rvalid_q && cpu_rready) begin
          buf_d = buf_q >> WORD_W;
          if (wcnt_q == WORD_LAST) begin
            wcnt_d  = '0;
            lcnt_d  = lcnt_q + CNT_W'(1);
            state_d = last_line_c ? S_DONE : S_RD_WAIT;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
      end

      S_WR_GO: begin
        wcnt_d  = '0;
        state_d = S_WR_FILL;
      end

      S_WR_FILL: begin
        if (cpu_wvalid && wready_q) begin
          buf_d[int'(wcnt_q) * WORD_W +: WORD_W] = cpu_wdata;
          if (wcnt_q == WORD_LAST) begin
            wcnt_d  = '0;
            state_d = S_WR_PUSH;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
      end

      S_WR_PUSH: begin
        if (!host_full) begin
          wr_en_c = 1'b1;
          lcnt_d  = lcnt_q + CNT_W'(1);
          state_d = last_line_c ? S_WR_WAIT : S_WR_FILL;
        end
      end

      S_WR_WAIT: begin
        if (host_wr_done) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, buffer, counters and latched transfer descriptors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      buf_q     <= '0;
      wcnt_q    <= '0;
      lcnt_q    <= '0;
      size_q    <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      rd_size_q <= '0;
      wr_size_q <= '0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      wcnt_q    <= wcnt_d;
      lcnt_q    <= lcnt_d;
      size_q    <= size_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      rd_size_q <= rd_size_d;
      wr_size_q <= wr_size_d;
    end
  end

  // Status and handshake flags registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q   <= 1'b1;
      rd_go_q   <= 1'b0;
      wr_go_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      wready_q  <= 1'b0;
      tx_done_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ready_q   <= (state_d == S_IDLE);
      rd_go_q   <= (state_d == S_RD_GO);
      wr_go_q   <= (state_d == S_WR_GO);
      rvalid_q  <= (state_d == S_RD_DRAIN);
      wready_q  <= (state_d == S_WR_FILL);
      tx_done_q <= (state_d == S_DONE);
      err_q     <= err_d;
    end
  end

  // FIFO strobes must react to empty/full in the same cycle.
  assign host_rd_en   = rd_en_c;
  assign host_wr_en   = wr_en_c;

  assign ready        = ready_q;
  assign tx_done      = tx_done_q;
  assign err          = err_q;
  assign cpu_rvalid   = rvalid_q;
  assign cpu_wready   = wready_q;
  assign cpu_rdata    = buf_q[WORD_W-1:0];
  assign host_rd_go   = rd_go_q;
  assign host_wr_go   = wr_go_q;
  assign host_rd_addr = rd_addr_q;
  assign host_wr_addr = wr_addr_q;
  assign host_rd_size = rd_size_q;
  assign host_wr_size = wr_size_q;
  assign host_wr_data = buf_q;

endmodule

// File: tb/tb_burst_mem_ctrl.sv
// Directed testbench for burst_mem_ctrl with small DMA FIFO / CPU stream models.
module tb_burst_mem_ctrl;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned LINE_W    = 512;
  localparam int unsigned ADDR_W    = 64;
  localparam int unsigned SIZE_W    = 33;
  localparam int unsigned MAX_LINES = 16;
  localparam int unsigned CNT_W     = $clog2(MAX_LINES) + 1;
  localparam int unsigned WPL       = LINE_W / WORD_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        op;
  logic [ADDR_W-1:0] io_address;
  logic [CNT_W-1:0]  num_lines;
  logic [WORD_W-1:0] cpu_wdata;
  logic              cpu_wvalid;
  logic              cpu_wready;
  logic [WORD_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic              cpu_rready;
  logic              ready;
  logic              tx_done;
  logic              err;
  logic [LINE_W-1:0] host_rd_data;
  logic              host_empty;
  logic              host_full;
  logic              host_wr_done;
  logic              host_rd_en;
  logic              host_wr_en;
  logic              host_rd_go;
  logic              host_wr_go;
  logic [ADDR_W-1:0] host_rd_addr;
  logic [ADDR_W-1:0] host_wr_addr;
  logic [SIZE_W-1:0] host_rd_size;
  logic [SIZE_W-1:0] host_wr_size;
  logic [LINE_W-1:0] host_wr_data;

  burst_mem_ctrl #(
    .WORD_W(WORD_W), .LINE_W(LINE_W), .ADDR_W(ADDR_W),
    .SIZE_W(SIZE_W), .MAX_LINES(MAX_LINES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .io_address(io_address),
    .num_lines(num_lines), .cpu_wdata(cpu_wdata), .cpu_wvalid(cpu_wvalid),
    .cpu_wready(cpu_wready), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .cpu_rready(cpu_rready), .ready(ready), .tx_done(tx_done), .err(err),
    .host_rd_data(host_rd_data), .host_empty(host_empty), .host_full(host_full),
    .host_wr_done(host_wr_done), .host_rd_en(host_rd_en), .host_wr_en(host_wr_en),
    .host_rd_go(host_rd_go), .host_wr_go(host_wr_go),
    .host_rd_addr(host_rd_addr), .host_wr_addr(host_wr_addr),
    .host_rd_size(host_rd_size), .host_wr_size(host_wr_size),
    .host_wr_data(host_wr_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state and event counters.
  logic [LINE_W-1:0] rdq[$];
  logic [WORD_W-1:0] wq[$];
  logic [WORD_W-1:0] rd_words[$];
  logic [LINE_W-1:0] wr_lines[$];
  int cyc, op_cyc, rd_go_cyc, wr_en_cyc, last_wacc_cyc;
  int n_rd_go, n_wr_go, n_rd_en, n_wr_en, n_tx, n_err, n_not_ready, viol, words_acc;
  bit rd_gap, rr_toggle, full_trig;
  int full_left;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] make_line(input int base);
    logic [LINE_W-1:0] l;
    l = '0;
    for (int k = 0; k < int'(WPL); k++) l[k*WORD_W +: WORD_W] = WORD_W'(base + k);
    return l;
  endfunction

  task automatic clear_counts();
    n_rd_go = 0; n_wr_go = 0; n_rd_en = 0; n_wr_en = 0; n_tx = 0; n_err = 0;
    n_not_ready = 0; viol = 0; words_acc = 0; rd_go_cyc = -1; wr_en_cyc = -1;
    last_wacc_cyc = -1; rd_gap = 0; rr_toggle = 0; full_trig = 0; full_left = 0;
    rd_words.delete(); wr_lines.delete();
  endtask

  task automatic drive_models();
    host_empty   = (rdq.size() == 0) || (rd_gap && ((cyc % 3) == 1));
    host_rd_data = (rdq.size() > 0) ? rdq[0] : '0;
    cpu_rready   = rr_toggle ? ((cyc % 5) != 2) : 1'b1;
    cpu_wvalid   = (wq.size() > 0);
    cpu_wdata    = (wq.size() > 0) ? wq[0] : '0;
    host_full    = full_trig && (words_acc == 32) && (full_left > 0);
    if (host_full) full_left--;
  endtask

  // One clock: observe at negedge, then update the models after the edge.
  task automatic tick();
    bit pop, wacc;
    logic [LINE_W-1:0] tl;
    logic [WORD_W-1:0] tw;
    @(negedge clk);
    cyc++;
    pop = 0; wacc = 0;
    if (host_rd_en) begin n_rd_en++; pop = 1; if (host_empty) viol++; end
    if (host_wr_en) begin
      n_wr_en++; wr_en_cyc = cyc; wr_lines.push_back(host_wr_data);
      if (host_full) viol++;
    end
    if (host_rd_en && host_wr_en) viol++;
    if (host_rd_go) begin n_rd_go++; rd_go_cyc = cyc; end
    if (host_wr_go) n_wr_go++;
    if (tx_done) n_tx++;
    if (err) n_err++;
    if (!ready) n_not_ready++;
    if (cpu_rvalid && cpu_rready) rd_words.push_back(cpu_rdata);
    if (cpu_wvalid && cpu_wready) begin wacc = 1; words_acc++; last_wacc_cyc = cyc; end
    @(posedge clk);
    #1;
    if (pop && rdq.size() > 0) tl = rdq.pop_front();
    if (wacc && wq.size() > 0) tw = wq.pop_front();
    drive_models();
  endtask

  task automatic start_op(input logic [1:0] o, input logic [63:0] a, input int n);
    op = o; io_address = a; num_lines = CNT_W'(n);
    op_cyc = cyc + 1;
    tick();
    op = 2'b00;
  endtask

  task automatic wait_tx(input string tag, input int budget);
    int b;
    b = 0;
    while (n_tx == 0 && b < budget) begin tick(); b++; end
    check_val({tag, "_done_in_time"}, 64'(n_tx > 0), 64'd1);
  endtask

  task automatic check_words(input string tag, input int base, input int n);
    check_val({tag, "_count"}, 64'(rd_words.size()), 64'(n));
    for (int i = 0; i < n && i < rd_words.size(); i++)
      check_val($sformatf("%s_w%0d", tag, i), 64'(rd_words[i]), 64'(base + i));
  endtask

  initial begin
    rst_n = 1'b0; op = 2'b00; io_address = '0; num_lines = '0;
    host_wr_done = 1'b0; cyc = 0; op_cyc = 0;
    clear_counts();
    drive_models();
    #12;
    check_val("reset_flags",
      64'({ready, tx_done, err, cpu_wready, cpu_rvalid, host_rd_en, host_wr_en,
           host_rd_go, host_wr_go}), 64'h100);
    check_val("reset_rd_addr", host_rd_addr, 64'h0);
    check_val("reset_wr_size", 64'(host_wr_size), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single-line read.
    rdq.push_back(make_line(0));
    drive_models();
    start_op(2'b01, 64'h1000, 1);
    wait_tx("rd1", 200);
    tick();
    check_val("rd1_go_latency", 64'(rd_go_cyc - op_cyc), 64'd1);
    check_val("rd1_go_count", 64'(n_rd_go), 64'd1);
    check_val("rd1_size", 64'(host_rd_size), 64'd1);
    check_val("rd1_addr", host_rd_addr, 64'h1000);
    check_val("rd1_rd_en", 64'(n_rd_en), 64'd1);
    check_val("rd1_tx_count", 64'(n_tx), 64'd1);
    check_val("rd1_ready", 64'(ready), 64'd1);
    check_words("rd1", 0, 16);

    // Three-line write with a full stall on line 2.
    clear_counts();
    full_trig = 1; full_left = 5;
    for (int i = 0; i < 48; i++) wq.push_back(WORD_W'(i));
    drive_models();
    start_op(2'b10, 64'h4000, 3);
    for (int b = 0; b < 300 && n_wr_en < 3; b++) tick();
    check_val("wr3_pushes", 64'(n_wr_en), 64'd3);
    check_val("wr3_last_push_latency", 64'(wr_en_cyc - last_wacc_cyc), 64'd1);
    repeat (4) tick();
    check_val("wr3_no_done_before_wr_done", 64'(n_tx), 64'd0);
    host_wr_done = 1'b1;
    tick();
    host_wr_done = 1'b0;
    wait_tx("wr3", 10);
    check_val("wr3_go_count", 64'(n_wr_go), 64'd1);
    check_val("wr3_size", 64'(host_wr_size), 64'd3);
    check_val("wr3_addr", host_wr_addr, 64'h4000);
    check_val("wr3_no_push_while_full", 64'(viol), 64'd0);
    check_val("wr3_full_used", 64'(full_left), 64'd0);
    for (int l = 0; l < 3 && l < wr_lines.size(); l++)
      for (int k = 0; k < int'(WPL); k++)
        check_val($sformatf("wr3_l%0d_w%0d", l, k),
                  64'(wr_lines[l][k*WORD_W +: WORD_W]), 64'(l*16 + k));

    // Four-line read under empty gaps and rready toggling.
    clear_counts();
    rd_gap = 1; rr_toggle = 1;
    for (int l = 0; l < 4; l++) rdq.push_back(make_line(200 + l*16));
    drive_models();
    start_op(2'b01, 64'h8000, 4);
    wait_tx("rd4", 600);
    check_val("rd4_rd_en", 64'(n_rd_en), 64'd4);
    check_val("rd4_no_rd_en_empty", 64'(viol), 64'd0);
    check_val("rd4_size", 64'(host_rd_size), 64'd4);
    check_words("rd4", 200, 64);

    // Illegal sizes and a reserved op.
    clear_counts();
    drive_models();
    start_op(2'b10, 64'hDEAD, 0);
    repeat (2) tick();
    check_val("err_zero", 64'(n_err), 64'd1);
    start_op(2'b10, 64'hDEAD, 17);
    repeat (2) tick();
    check_val("err_17", 64'(n_err), 64'd2);
    start_op(2'b11, 64'hDEAD, 1);
    repeat (3) tick();
    check_val("err_reserved_ignored", 64'(n_err), 64'd2);
    check_val("err_no_go", 64'(n_wr_go + n_rd_go), 64'd0);
    check_val("err_ready_held", 64'(n_not_ready), 64'd0);
    check_val("err_addr_kept", host_wr_addr, 64'h4000);

    // Reset in the middle of a write burst.
    clear_counts();
    for (int i = 0; i < 16; i++) wq.push_back(WORD_W'(i + 1));
    drive_models();
    start_op(2'b10, 64'h5000, 2);
    for (int b = 0; b < 50 && words_acc < 7; b++) tick();
    check_val("rst_words_before", 64'(words_acc), 64'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_flags",
      64'({ready, tx_done, err, cpu_wready, cpu_rvalid, host_rd_en, host_wr_en,
           host_rd_go, host_wr_go}), 64'h100);
    check_val("rst_wdata_clear", 64'(|host_wr_data), 64'd0);
    check_val("rst_wr_addr", host_wr_addr, 64'h0);
    check_val("rst_wr_size", 64'(host_wr_size), 64'h0);
    wq.delete();
    drive_models();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check_val("rst_ready_after", 64'(ready), 64'd1);
    check_val("rst_no_push", 64'(n_wr_en), 64'd0);
    clear_counts();
    rdq.push_back(make_line(100));
    drive_models();
    start_op(2'b01, 64'h6000, 1);
    wait_tx("rst_rd", 200);
    check_val("rst_rd_go", 64'(n_rd_go), 64'd1);
    check_words("rst_rd", 100, 16);

    // Write op presented while a read burst is in flight.
    repeat (2) tick();
    clear_counts();
    drive_models();
    start_op(2'b01, 64'h2000, 1);
    op = 2'b10; io_address = 64'h3000; num_lines = CNT_W'(1);
    repeat (4) tick();
    op = 2'b00;
    rdq.push_back(make_line(300));
    drive_models();
    wait_tx("ovl", 200);
    tick();
    check_val("ovl_no_wr_go", 64'(n_wr_go), 64'd0);
    check_val("ovl_rd_go", 64'(n_rd_go), 64'd1);
    check_val("ovl_rd_addr", host_rd_addr, 64'h2000);
    check_val("ovl_wr_addr", host_wr_addr, 64'h0);
    check_val("ovl_tx_count", 64'(n_tx), 64'd1);
    check_words("ovl", 300, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
